sisc_exec_ctrl: RTL and testbench

SISC_EXEC_CTRL -- requirements
Module: sisc_exec_ctrl

---
 rtl/sisc_exec_ctrl_if.sv | 53 +++++
 rtl/sisc_exec_ctrl.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_sisc_exec_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sisc_exec_ctrl_if.sv
// sisc_exec_ctrl_if -- bundle between the SISC execution controller and its
// datapath (register file, ALU operands, PC logic, data memory, swap unit).
//
// Signals:
//   IR, rsa, rsb, STAT, pc_inc    : datapath -> controller (instruction, operands, flags, PC+1)
//   alu_result, stat, stat_en     : ALU result, new {C,V,N,Z} flags and status-register write enable
//   br_addr                       : branch target
//   RF_WE .. SWAP_REG, ALU_OP,
//   RD_SEL                        : controller strobes and mux selects
//
// Modports:
//   master : the execution controller (drives strobes and ALU/branch results)
//   slave  : the datapath side
interface sisc_exec_ctrl_if;
    logic [31:0] IR;
    logic [31:0] rsa;
    logic [31:0] rsb;
    logic [3:0]  STAT;
    logic [15:0] pc_inc;

    logic [31:0] alu_result;
    logic [3:0]  stat;
    logic        stat_en;
    logic [15:0] br_addr;

    logic        RF_WE;
    logic        WB_SEL;
    logic        PC_SEL;
    logic        PC_WRITE;
    logic        PC_RST;
    logic        BR_SEL;
    logic        MM_SEL;
    logic        DM_WE;
    logic        SWAP_MUX;
    logic        SWAP_DATA;
    logic        SWAP_REG;
    logic [1:0]  ALU_OP;
    logic [1:0]  RD_SEL;

    modport master (
        input  IR, rsa, rsb, STAT, pc_inc,
        output alu_result, stat, stat_en, br_addr,
        output RF_WE, WB_SEL, PC_SEL, PC_WRITE, PC_RST, BR_SEL, MM_SEL, DM_WE,
        output SWAP_MUX, SWAP_DATA, SWAP_REG, ALU_OP, RD_SEL
    );

    modport slave (
        output IR, rsa, rsb, STAT, pc_inc,
        input  alu_result, stat, stat_en, br_addr,
        input  RF_WE, WB_SEL, PC_SEL, PC_WRITE, PC_RST, BR_SEL, MM_SEL, DM_WE,
        input  SWAP_MUX, SWAP_DATA, SWAP_REG, ALU_OP, RD_SEL
    );
endinterface

// File: rtl/sisc_exec_ctrl.sv
// sisc_exec_ctrl -- multi-cycle execution controller for the SISC processor.
//
// Sequences each instruction through FETCH, DECODE, EXECUTE, MEM, WRITEBACK
// (and WB2 for SWP), generates the registered control strobes for the datapath,
// and computes the combinational ALU result/flags and the branch target.
//
// Ports:
//   CLK   : rising-edge clock
//   RST_F : synchronous active-low reset (forces START from any state)
//   bus   : sisc_exec_ctrl_if.master (instruction/operands in, strobes/results out)
//
// Configuration:
//   SISC_SWAP_EN : when defined, opcode 0111 (SWP) performs the two-cycle
//                  register swap; when undefined it executes as a NOP and the
//                  swap strobes stay 0.
module sisc_exec_ctrl (
    input  logic             CLK,
    input  logic             RST_F,
    sisc_exec_ctrl_if.master bus
);

`ifdef SISC_SWAP_EN
    localparam logic SWAP_EN = 1'b1;
`else
    localparam logic SWAP_EN = 1'b0;
`endif

    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_ADDI = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_LOD  = 4'b0101;
    localparam logic [3:0] OP_STR  = 4'b0110;
    localparam logic [3:0] OP_SWP  = 4'b0111;
    localparam logic [3:0] OP_BRR  = 4'b1000;
    localparam logic [3:0] OP_BRA  = 4'b1001;
    localparam logic [3:0] OP_BNR  = 4'b1010;
    localparam logic [3:0] OP_BNA  = 4'b1011;
    localparam logic [3:0] OP_HLT  = 4'b1111;

    typedef enum logic [2:0] {
        ST_START, ST_FETCH, ST_DECODE, ST_EXECUTE,
        ST_MEM, ST_WRITEBACK, ST_WB2, ST_HALT
    } state_t;

    state_t      state_r;
    logic [3:0]  op_r;
    logic [3:0]  mm_r;
    logic [1:0]  alu_op_r;
    logic [1:0]  rd_sel_r;
    logic        wb_sel_r;
    logic        mm_sel_r;
    logic        br_sel_r;
    logic        rf_we_r;
    logic        pc_sel_r;
    logic        pc_write_r;
    logic        pc_rst_r;
    logic        dm_we_r;
    logic        swap_mux_r;
    logic        swap_data_r;
    logic        swap_reg_r;
    logic        stat_en_r;

    logic [1:0]  dec_alu_op_s;
    logic [1:0]  dec_rd_sel_s;
    logic        dec_wb_sel_s;
    logic        dec_mm_sel_s;
    logic        dec_br_sel_s;

    logic [31:0] opb_s;
    logic        cin_s;
    logic [32:0] sum_s;
    logic [31:0] res_s;
    logic        c_s;
    logic        v_s;
    logic        quiet_s;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI) || (op == OP_AND);
    endfunction

    function automatic logic is_swap(input logic [3:0] op);
        return SWAP_EN && (op == OP_SWP);
    endfunction

    function automatic logic writes_rf(input logic [3:0] op);
        return is_alu_op(op) || (op == OP_LOD) || is_swap(op);
    endfunction

    // BRR/BRA take the branch when any selected flag is set, BNR/BNA when none is.
    function automatic logic branch_taken(input logic [3:0] op, input logic [3:0] mm,
                                          input logic [3:0] st);
        logic hit;
        hit = ((st & mm) != 4'b0000);
        case (op)
            OP_BRR, OP_BRA: return hit;
            OP_BNR, OP_BNA: return !hit;
            default:        return 1'b0;
        endcase
    endfunction

    // Decode of the per-instruction selects that stay constant from DECODE onward.
    always_comb begin
        dec_alu_op_s = 2'b00;
        dec_rd_sel_s = 2'b00;
        dec_wb_sel_s = 1'b0;
        dec_mm_sel_s = 1'b0;
        dec_br_sel_s = 1'b0;
        case (bus.IR[31:28])
            OP_SUB:  dec_alu_op_s = 2'b01;
            OP_ADDI: begin
                dec_alu_op_s = 2'b10;
                dec_rd_sel_s = 2'b01;
            end
            OP_AND:  dec_alu_op_s = 2'b11;
            // Memory address is either the raw immediate or rs+imm through the ALU.
            OP_LOD:  begin
                dec_alu_op_s = 2'b10;
                dec_rd_sel_s = 2'b01;
                dec_wb_sel_s = 1'b1;
                dec_mm_sel_s = bus.IR[24];
            end
            OP_STR:  begin
                dec_alu_op_s = 2'b10;
                dec_mm_sel_s = bus.IR[24];
            end
            OP_SWP:  dec_rd_sel_s = SWAP_EN ? 2'b10 : 2'b00;
            OP_BRA, OP_BNA: dec_br_sel_s = 1'b1;
            default: dec_alu_op_s = 2'b00;
        endcase
    end

    // Instruction sequencer; every strobe is registered for the state being entered.
    always_ff @(posedge CLK) begin
        if (!RST_F) begin
            state_r     <= ST_START;
            op_r        <= 4'b0000;
            mm_r        <= 4'b0000;
            alu_op_r    <= 2'b00;
            rd_sel_r    <= 2'b00;
            wb_sel_r    <= 1'b0;
            mm_sel_r    <= 1'b0;
            br_sel_r    <= 1'b0;
            rf_we_r     <= 1'b0;
            pc_sel_r    <= 1'b0;
            pc_write_r  <= 1'b0;
            pc_rst_r    <= 1'b1;
            dm_we_r     <= 1'b0;
            swap_mux_r  <= 1'b0;
            swap_data_r <= 1'b0;
            swap_reg_r  <= 1'b0;
            stat_en_r   <= 1'b0;
        end else begin
            rf_we_r     <= 1'b0;
            pc_sel_r    <= 1'b0;
            pc_write_r  <= 1'b0;
            pc_rst_r    <= 1'b0;
            dm_we_r     <= 1'b0;
            swap_mux_r  <= 1'b0;
            swap_data_r <= 1'b0;
            swap_reg_r  <= 1'b0;
            stat_en_r   <= 1'b0;
            case (state_r)
                ST_START: state_r <= ST_FETCH;
                ST_FETCH: begin
                    state_r  <= ST_DECODE;
                    op_r     <= bus.IR[31:28];
                    mm_r     <= bus.IR[27:24];
                    alu_op_r <= dec_alu_op_s;
                    rd_sel_r <= dec_rd_sel_s;
                    wb_sel_r <= dec_wb_sel_s;
                    mm_sel_r <= dec_mm_sel_s;
                    br_sel_r <= dec_br_sel_s;
                end
                ST_DECODE: begin
                    if (op_r == OP_HLT) begin
                        state_r <= ST_HALT;
                    end else begin
                        state_r   <= ST_EXECUTE;
                        stat_en_r <= is_alu_op(op_r);
                    end
                end
                ST_EXECUTE: begin
                    state_r <= ST_MEM;
                    dm_we_r <= (op_r == OP_STR);
                end
                ST_MEM: begin
                    state_r <= ST_WRITEBACK;
                    rf_we_r <= writes_rf(op_r);
                    if (is_swap(op_r)) begin
                        // First swap write: rs receives the old rt (rsb).
                        swap_mux_r  <= 1'b1;
                        swap_data_r <= 1'b1;
                    end else begin
                        pc_write_r <= 1'b1;
                        pc_sel_r   <= branch_taken(op_r, mm_r, bus.STAT);
                    end
                end
                ST_WRITEBACK: begin
                    if (is_swap(op_r)) begin
                        // Second swap write: rt receives the old rs.
                        state_r    <= ST_WB2;
                        rf_we_r    <= 1'b1;
                        swap_mux_r <= 1'b1;
                        swap_reg_r <= 1'b1;
                        pc_write_r <= 1'b1;
                    end else begin
                        state_r  <= ST_FETCH;
                        alu_op_r <= 2'b00;
                        rd_sel_r <= 2'b00;
                        wb_sel_r <= 1'b0;
                        mm_sel_r <= 1'b0;
                        br_sel_r <= 1'b0;
                    end
                end
                ST_WB2: begin
                    state_r  <= ST_FETCH;
                    alu_op_r <= 2'b00;
                    rd_sel_r <= 2'b00;
                    wb_sel_r <= 1'b0;
                    mm_sel_r <= 1'b0;
                    br_sel_r <= 1'b0;
                end
                ST_HALT: state_r <= ST_HALT;
                default: state_r <= ST_START;
            endcase
        end
    end

    // ALU: ADD/SUB/ADDI share one 33-bit adder (SUB as rsa + ~rsb + 1); AND bypasses it.
    always_comb begin
        opb_s = bus.rsb;
        cin_s = 1'b0;
        case (alu_op_r)
            2'b00: begin
                opb_s = bus.rsb;
                cin_s = 1'b0;
            end
            2'b01: begin
                opb_s = ~bus.rsb;
                cin_s = 1'b1;
            end
            2'b10: begin
                opb_s = {{16{bus.IR[15]}}, bus.IR[15:0]};
                cin_s = 1'b0;
            end
            default: begin
                opb_s = bus.rsb;
                cin_s = 1'b0;
            end
        endcase
        sum_s = {1'b0, bus.rsa} + {1'b0, opb_s} + {32'd0, cin_s};
        if (alu_op_r == 2'b11) begin
            res_s = bus.rsa & bus.rsb;
            c_s   = 1'b0;
            v_s   = 1'b0;
        end else begin
            res_s = sum_s[31:0];
            c_s   = sum_s[32];
            v_s   = (bus.rsa[31] == opb_s[31]) && (res_s[31] != bus.rsa[31]);
        end
    end

    // START and HALT drive every output low apart from PC_RST in START.
    assign quiet_s = (state_r == ST_START) || (state_r == ST_HALT);

    assign bus.alu_result = quiet_s ? 32'd0 : res_s;
    assign bus.stat       = quiet_s ? 4'b0000 : {c_s, v_s, res_s[31], (res_s == 32'd0)};
    assign bus.br_addr    = quiet_s ? 16'd0 :
                            (br_sel_r ? bus.IR[15:0] : (bus.pc_inc + bus.IR[15:0]));

    // Write strobes are qualified by RST_F so nothing is written in a reset cycle,
    // even when reset arrives mid-instruction before the registers clear.
    assign bus.RF_WE     = rf_we_r & RST_F;
    assign bus.DM_WE     = dm_we_r & RST_F;
    assign bus.PC_WRITE  = pc_write_r & RST_F;
    assign bus.WB_SEL    = wb_sel_r;
    assign bus.PC_SEL    = pc_sel_r;
    assign bus.PC_RST    = pc_rst_r;
    assign bus.BR_SEL    = br_sel_r;
    assign bus.MM_SEL    = mm_sel_r;
    assign bus.SWAP_MUX  = swap_mux_r;
    assign bus.SWAP_DATA = swap_data_r;
    assign bus.SWAP_REG  = swap_reg_r;
    assign bus.stat_en   = stat_en_r;
    assign bus.ALU_OP    = alu_op_r;
    assign bus.RD_SEL    = rd_sel_r;

endmodule

// File: tb/tb_sisc_exec_ctrl.sv
// tb_sisc_exec_ctrl -- self-checking bench for sisc_exec_ctrl.
// Directed vector table, hand-written reset/halt sequences and randomized
// instructions checked against a rule-based reference model.
module tb_sisc_exec_ctrl;

`ifdef SISC_SWAP_EN
    localparam bit SWAP_EN = 1'b1;
`else
    localparam bit SWAP_EN = 1'b0;
`endif

    logic CLK;
    logic RST_F;
    int   n_tests;
    int   n_fail;

    sisc_exec_ctrl_if bus ();

    sisc_exec_ctrl dut (
        .CLK   (CLK),
        .RST_F (RST_F),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  mm;
        logic [31:0] a;
        logic [31:0] b;
        logic [15:0] imm;
        logic [3:0]  st;
        logic [15:0] pc;
        bit          chk_alu;
        logic [31:0] exp_res;
        logic [3:0]  exp_stat;
        logic [15:0] exp_br;
    } vec_t;

    vec_t vecs [10];

    // Packed view of the control outputs:
    // {RF_WE,WB_SEL,PC_SEL,PC_WRITE,PC_RST,BR_SEL,MM_SEL,DM_WE,SWAP_MUX,SWAP_DATA,SWAP_REG,stat_en,ALU_OP,RD_SEL}
    function automatic logic [15:0] ctrl_vec();
        return {bus.RF_WE, bus.WB_SEL, bus.PC_SEL, bus.PC_WRITE, bus.PC_RST, bus.BR_SEL,
                bus.MM_SEL, bus.DM_WE, bus.SWAP_MUX, bus.SWAP_DATA, bus.SWAP_REG,
                bus.stat_en, bus.ALU_OP, bus.RD_SEL};
    endfunction

    function automatic logic [1:0] exp_aop(input logic [3:0] op);
        case (op)
            4'h2:       return 2'b01;
            4'h3:       return 2'b10;
            4'h4:       return 2'b11;
            4'h5, 4'h6: return 2'b10;
            default:    return 2'b00;
        endcase
    endfunction

    function automatic bit is_swp(input logic [3:0] op);
        return SWAP_EN && (op == 4'h7);
    endfunction

    function automatic int instr_len(input logic [3:0] op);
        if (op == 4'hF) return 2;
        return is_swp(op) ? 6 : 5;
    endfunction

    // ALU_OP is unspecified for immediate-addressed LOD/STR.
    function automatic logic [15:0] care_ctrl(input logic [3:0] op, input logic [3:0] mm);
        if ((op == 4'h5 || op == 4'h6) && mm[0]) return 16'hFFF3;
        return 16'hFFFF;
    endfunction

    // Expected strobes in cycle k of an instruction (k=0 is the fetch cycle).
    function automatic logic [15:0] exp_ctrl(input logic [3:0] op, input logic [3:0] mm,
                                             input logic [3:0] st, input int k);
        bit alu, lod, str, swp, brn, taken, held;
        int last;
        logic [15:0] v;
        v = 16'h0000;
        if (op == 4'hF) return v;
        alu   = (op >= 4'h1) && (op <= 4'h4);
        lod   = (op == 4'h5);
        str   = (op == 4'h6);
        swp   = is_swp(op);
        brn   = (op >= 4'h8) && (op <= 4'hB);
        taken = brn && (((op == 4'h8) || (op == 4'h9)) ? ((st & mm) != 4'h0) : ((st & mm) == 4'h0));
        last  = swp ? 5 : 4;
        held  = (k >= 1);
        v[15] = ((k == 4) && (alu || lod || swp)) || ((k == 5) && swp);
        v[14] = held && lod;
        v[13] = (k == last) && taken;
        v[12] = (k == last);
        v[10] = held && ((op == 4'h9) || (op == 4'hB));
        v[9]  = held && (lod || str) && mm[0];
        v[8]  = (k == 3) && str;
        v[7]  = swp && (k >= 4);
        v[6]  = swp && (k == 4);
        v[5]  = swp && (k == 5);
        v[4]  = (k == 2) && alu;
        v[3:2] = held ? exp_aop(op) : 2'b00;
        v[1:0] = !held ? 2'b00 : ((op == 4'h3 || op == 4'h5) ? 2'b01 : (swp ? 2'b10 : 2'b00));
        return v;
    endfunction

    // Reference ALU from plain integer arithmetic: {C,V,N,Z,result}.
    function automatic logic [35:0] model_alu(input logic [1:0] aop, input logic [31:0] a,
                                              input logic [31:0] b, input logic [15:0] imm);
        longint sa, sb, sr;
        longint unsigned ua, ub;
        logic [31:0] r, bx;
        bit c, v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        bx = {{16{imm[15]}}, imm};
        c = 1'b0;
        v = 1'b0;
        case (aop)
            2'b00: begin
                sr = sa + sb;
                c  = ((ua + ub) >> 32) != 0;
            end
            2'b01: begin
                sr = sa - sb;
                c  = (a >= b);
            end
            2'b10: begin
                sr = sa + longint'($signed(imm));
                c  = ((ua + longint'(bx)) >> 32) != 0;
            end
            default: sr = longint'($signed(a & b));
        endcase
        r = sr[31:0];
        if (aop != 2'b11) v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return {c, v, r[31], (r == 32'd0), r};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_ctrl(input string name, input logic [15:0] exp, input logic [15:0] care);
        logic [15:0] act;
        act = ctrl_vec();
        n_tests++;
        if ((act & care) !== (exp & care)) begin
            n_fail++;
            $display("FAIL %s: ctrl got %h expected %h (care %h)", name, act, exp, care);
        end
    endtask

    // Runs one instruction from the fetch edge; data outputs are captured in EXECUTE.
    task automatic do_instr(input logic [3:0] op, input logic [3:0] mm, input logic [31:0] a,
                            input logic [31:0] b, input logic [15:0] imm, input logic [3:0] st,
                            input logic [15:0] pc, output logic [31:0] res,
                            output logic [3:0] fl, output logic [15:0] br);
        res = 32'd0;
        fl  = 4'd0;
        br  = 16'd0;
        bus.IR     = {op, mm, 8'h12, imm};
        bus.rsa    = a;
        bus.rsb    = b;
        bus.STAT   = st;
        bus.pc_inc = pc;
        for (int k = 0; k < instr_len(op); k++) begin
            @(posedge CLK);
            @(negedge CLK);
            check_ctrl($sformatf("ctrl op%h mm%h st%h cyc%0d", op, mm, st, k),
                       exp_ctrl(op, mm, st, k), care_ctrl(op, mm));
            if (k == 2) begin
                res = bus.alu_result;
                fl  = bus.stat;
                br  = bus.br_addr;
            end
        end
    endtask

    task automatic do_reset();
        RST_F = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_ctrl("reset_start", 16'h0800, 16'hFFFF);
        check("reset_alu", bus.alu_result, 32'd0);
        RST_F = 1'b1;
    endtask

    initial begin
        logic [31:0] res;
        logic [3:0]  fl;
        logic [15:0] br;
        logic [35:0] m;
        logic [3:0]  op, mm;
        logic [31:0] a, b;
        logic [15:0] imm, pc;
        logic [3:0]  st;

        n_tests = 0;
        n_fail  = 0;

        //         op    mm    a             b             imm       st    pc        chk   res           stat     br
        vecs[0] = '{4'h1, 4'h0, 32'hFFFFFFFF, 32'h00000001, 16'h3000, 4'h0, 16'h0000, 1'b1, 32'h00000000, 4'b1001, 16'h3000};
        vecs[1] = '{4'h2, 4'h0, 32'h7FFFFFFF, 32'hFFFFFFFF, 16'h3000, 4'h0, 16'h0000, 1'b1, 32'h80000000, 4'b0110, 16'h3000};
        vecs[2] = '{4'h8, 4'h1, 32'h00000000, 32'h00000000, 16'hFFFE, 4'h1, 16'h0010, 1'b1, 32'h00000000, 4'b0001, 16'h000E};
        vecs[3] = '{4'h8, 4'h1, 32'h00000000, 32'h00000000, 16'hFFFE, 4'h0, 16'h0010, 1'b1, 32'h00000000, 4'b0001, 16'h000E};
        vecs[4] = '{4'h4, 4'h0, 32'hF0F0F0F0, 32'h0FF00FF0, 16'h0000, 4'h0, 16'h0000, 1'b1, 32'h00F000F0, 4'b0000, 16'h0000};
        vecs[5] = '{4'h3, 4'h0, 32'h00000010, 32'h12345678, 16'hFFF0, 4'h0, 16'h0000, 1'b1, 32'h00000000, 4'b1001, 16'hFFF0};
        vecs[6] = '{4'h9, 4'h4, 32'h00000001, 32'h00000002, 16'h1234, 4'h4, 16'h0010, 1'b1, 32'h00000003, 4'b0000, 16'h1234};
        vecs[7] = '{4'hA, 4'h2, 32'h80000000, 32'h80000000, 16'h0004, 4'h1, 16'h0100, 1'b1, 32'h00000000, 4'b1101, 16'h0104};
        vecs[8] = '{4'h6, 4'h1, 32'h00000000, 32'h00000000, 16'h0040, 4'h0, 16'h0000, 1'b0, 32'h00000000, 4'b0000, 16'h0040};
        vecs[9] = '{4'h7, 4'h0, 32'h00000005, 32'h00000007, 16'h0000, 4'h0, 16'h0000, 1'b1, 32'h0000000C, 4'b0000, 16'h0000};

        RST_F      = 1'b0;
        bus.IR     = 32'd0;
        bus.rsa    = 32'h00000005;
        bus.rsb    = 32'h00000003;
        bus.STAT   = 4'h0;
        bus.pc_inc = 16'h0001;
        do_reset();

        for (int i = 0; i < 10; i++) begin
            do_instr(vecs[i].op, vecs[i].mm, vecs[i].a, vecs[i].b, vecs[i].imm,
                     vecs[i].st, vecs[i].pc, res, fl, br);
            if (vecs[i].chk_alu) begin
                check($sformatf("vec%0d_alu", i), res, vecs[i].exp_res);
                check($sformatf("vec%0d_stat", i), {28'd0, fl}, {28'd0, vecs[i].exp_stat});
            end
            check($sformatf("vec%0d_br", i), {16'd0, br}, {16'd0, vecs[i].exp_br});
        end

        // Reset during the MEM cycle of a STR: write suppressed at once, START next.
        bus.IR = {4'h6, 4'h1, 8'h12, 16'h0040};
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        check("str_mem_dm_we", {31'd0, bus.DM_WE}, 32'd1);
        RST_F = 1'b0;
        #1;
        check("str_rst_dm_we_gated", {31'd0, bus.DM_WE}, 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        check_ctrl("str_rst_start", 16'h0800, 16'hFFFF);
        RST_F = 1'b1;

        // HLT: outputs stay quiet until reset.
        do_instr(4'hF, 4'h3, 32'hDEADBEEF, 32'h00000011, 16'h0100, 4'hF, 16'h0200, res, fl, br);
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            check_ctrl($sformatf("halt_ctrl%0d", i), 16'h0000, 16'hFFFF);
            check($sformatf("halt_data%0d", i), bus.alu_result | {12'd0, bus.stat, bus.br_addr}, 32'd0);
        end
        do_reset();
        do_instr(4'h1, 4'h0, 32'h00000002, 32'h00000003, 16'h0000, 4'h0, 16'h0000, res, fl, br);
        check("post_halt_add", res, 32'h00000005);

        // Randomized instruction stream against the reference model.
        for (int i = 0; i < 150; i++) begin
            op  = 4'($urandom_range(0, 14));
            mm  = 4'($urandom);
            st  = 4'($urandom);
            imm = 16'($urandom);
            pc  = 16'($urandom);
            a   = $urandom;
            b   = $urandom;
            if ((i % 5) == 0) a = 32'hFFFFFFFF;
            if ((i % 7) == 0) b = 32'h80000000;
            do_instr(op, mm, a, b, imm, st, pc, res, fl, br);
            m = model_alu(exp_aop(op), a, b, imm);
            if (!((op == 4'h5 || op == 4'h6) && mm[0])) begin
                check($sformatf("rnd%0d_alu", i), res, m[31:0]);
                check($sformatf("rnd%0d_stat", i), {28'd0, fl}, {28'd0, m[35:32]});
            end
            check($sformatf("rnd%0d_br", i), {16'd0, br},
                  {16'd0, ((op == 4'h9) || (op == 4'hB)) ? imm : 16'(pc + imm)});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
